// File: rtl/inst_cache.sv
// Direct-mapped instruction cache, one instruction per line, between ifetch and
// the memory controller. Hits answer next cycle; misses fetch one word and fill.
module inst_cache #(
    parameter int IDX_WIDTH  = 6,
    parameter int ADDR_WIDTH = 32,
    parameter int INST_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_in,
    input  logic                  rdy_in,
    input  logic                  flush,
    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_pc,
    output logic                  if_rdy,
    output logic [INST_WIDTH-1:0] if_inst,
    output logic                  busy,
    output logic                  mem_req,
    output logic [ADDR_WIDTH-1:0] mem_pc,
    input  logic                  mem_rdy,
    input  logic [INST_WIDTH-1:0] mem_inst,
    output logic [31:0]           hit_cnt,
    output logic [31:0]           miss_cnt
);
    localparam int LINES     = 1 << IDX_WIDTH;
    localparam int TAG_WIDTH = ADDR_WIDTH - IDX_WIDTH - 2;

    typedef enum logic {IDLE, MISS} state_t;

    state_t state, state_next;

    logic [LINES-1:0]      valid;
    logic [TAG_WIDTH-1:0]  tag_mem  [LINES];
    logic [INST_WIDTH-1:0] data_mem [LINES];
    logic                  drop;

    logic [IDX_WIDTH-1:0]  req_idx, fill_idx;
    logic [TAG_WIDTH-1:0]  req_tag, fill_tag;
    logic                  hit_line;
    logic                  do_hit, do_miss, do_fill, deliver;
    logic                  pc_unused;

    // Word offset bits never select anything.
    assign pc_unused = ^if_pc[1:0];

    assign req_idx  = if_pc[IDX_WIDTH+1:2];
    assign req_tag  = if_pc[ADDR_WIDTH-1:IDX_WIDTH+2];
    assign fill_idx = mem_pc[IDX_WIDTH+1:2];
    assign fill_tag = mem_pc[ADDR_WIDTH-1:IDX_WIDTH+2];
    assign hit_line = valid[req_idx] && (tag_mem[req_idx] == req_tag);
    assign busy     = (state == MISS);

    always_comb begin
        state_next = state;
        do_hit     = 1'b0;
        do_miss    = 1'b0;
        do_fill    = 1'b0;
        case (state)
            IDLE: begin
                if (if_req && !flush) begin
                    if (hit_line) begin
                        do_hit = 1'b1;
                    end else begin
                        do_miss    = 1'b1;
                        state_next = MISS;
                    end
                end
            end
            MISS: begin
                if (mem_rdy) begin
                    do_fill    = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // A flush arriving with the returning word still kills the response.
    assign deliver = do_fill && !(drop || flush);

    always_ff @(posedge clk or negedge rst_in) begin
        if (!rst_in) begin
            state <= IDLE;
        end else if (rdy_in) begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_in) begin
        if (!rst_in) begin
            if_rdy   <= 1'b0;
            if_inst  <= '0;
            mem_req  <= 1'b0;
            mem_pc   <= '0;
            drop     <= 1'b0;
            hit_cnt  <= '0;
            miss_cnt <= '0;
            valid    <= '0;
        end else if (rdy_in) begin
            if_rdy <= do_hit || deliver;
            if (do_hit) begin
                if_inst <= data_mem[req_idx];
            end else if (deliver) begin
                if_inst <= mem_inst;
            end
            if (do_hit && hit_cnt != '1) begin
                hit_cnt <= hit_cnt + 32'd1;
            end
            if (do_miss) begin
                mem_req <= 1'b1;
                mem_pc  <= {if_pc[ADDR_WIDTH-1:2], 2'b00};
                drop    <= 1'b0;
                if (miss_cnt != '1) begin
                    miss_cnt <= miss_cnt + 32'd1;
                end
            end
            if (state == MISS && flush) begin
                drop <= 1'b1;
            end
            if (do_fill) begin
                mem_req         <= 1'b0;
                valid[fill_idx] <= 1'b1;
            end
        end
    end

    // Tag/data arrays carry no reset; the valid bits guard them.
    always_ff @(posedge clk) begin
        if (rdy_in && do_fill) begin
            tag_mem[fill_idx]  <= fill_tag;
            data_mem[fill_idx] <= mem_inst;
        end
    end

endmodule
